// File: rtl/alu_seq_ctrl.sv
// rtl/alu_seq_ctrl.sv - registered ALU-control decoder with iterative MULT/DIV sequencer
//
// Decodes the 4-bit ALU class and the R-type func field into a registered 3-bit ALU code.
// MULT (unsigned shift-add) and DIV (unsigned restoring) run one bit per cycle into HI/LO.
// Optional feature macro: ALU_SEQ_DIV_EN (when undefined, DIV decodes as illegal and the
// divider is not built).
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   valid_in              request strobe, accepted when busy is low
//   UC_aluOp[3:0]         ALU class from the control unit
//   func[5:0]             R-type function field
//   op_a, op_b[WIDTH]     rs / rt operands, latched at accept
//   ALU_aluOp[2:0]        registered ALU operation code
//   out_valid             one-cycle pulse per accepted request
//   illegal               unknown class or func, registered with out_valid
//   busy                  iterative MULT/DIV in progress
//   done                  one-cycle pulse, hi/lo just loaded
//   hi, lo[WIDTH]         MULT product halves / DIV remainder and quotient
//   div_zero              sticky until next accept: last DIV had divisor 0
module alu_seq_ctrl #(
    parameter int         WIDTH      = 32,
    parameter logic [2:0] ILLEGAL_OP = 3'b110
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_in,
    input  logic [3:0]       UC_aluOp,
    input  logic [5:0]       func,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [2:0]       ALU_aluOp,
    output logic             out_valid,
    output logic             illegal,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL
`ifdef ALU_SEQ_DIV_EN
        , S_DIV
`endif
    } state_t;

    state_t               state, state_nxt;
    logic [CW-1:0]        cnt;
    logic [2*WIDTH-1:0]   acc;      // {upper, lower}: product or {remainder, quotient}
    logic [WIDTH-1:0]     opnd;     // multiplicand or divisor
    logic                 accept;
    logic                 last_iter;
    logic [2:0]           dec_op;
    logic                 dec_illegal;
    logic                 is_mult;
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_step;
`ifdef ALU_SEQ_DIV_EN
    logic                 is_div;
    logic [WIDTH:0]       div_tmp;
    logic [WIDTH:0]       div_rem;
    logic                 div_ge;
    logic [2*WIDTH-1:0]   div_step;
`endif

    assign accept    = valid_in && !busy;
    assign last_iter = (cnt == CW'(WIDTH - 1));

    // Class / func decode
    always_comb begin
        dec_op      = ILLEGAL_OP;
        dec_illegal = 1'b1;
        is_mult     = 1'b0;
`ifdef ALU_SEQ_DIV_EN
        is_div      = 1'b0;
`endif
        case (UC_aluOp)
            4'b0001, 4'b0100, 4'b1000: begin dec_op = 3'b010; dec_illegal = 1'b0; end
            4'b0000:                   begin dec_op = 3'b000; dec_illegal = 1'b0; end
            4'b0010:                   begin dec_op = 3'b001; dec_illegal = 1'b0; end
            4'b0011:                   begin dec_op = 3'b100; dec_illegal = 1'b0; end
            4'b0101:                   begin dec_op = 3'b011; dec_illegal = 1'b0; end
            4'b0110, 4'b1001:          begin dec_op = 3'b110; dec_illegal = 1'b0; end
            4'b0111: begin
                case (func)
                    6'b100100: begin dec_op = 3'b000; dec_illegal = 1'b0; end
                    6'b100101: begin dec_op = 3'b001; dec_illegal = 1'b0; end
                    6'b100000: begin dec_op = 3'b010; dec_illegal = 1'b0; end
                    6'b100010: begin dec_op = 3'b011; dec_illegal = 1'b0; end
                    6'b101010: begin dec_op = 3'b100; dec_illegal = 1'b0; end
                    6'b000000: begin dec_op = 3'b110; dec_illegal = 1'b0; end
                    6'b011000: begin dec_op = 3'b111; dec_illegal = 1'b0; is_mult = 1'b1; end
`ifdef ALU_SEQ_DIV_EN
                    6'b011010: begin dec_op = 3'b101; dec_illegal = 1'b0; is_div = 1'b1; end
`endif
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    // One shift-add step: add multiplicand when the multiplier LSB is set, then shift right
    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    assign mul_step = {mul_sum, acc[WIDTH-1:1]};

`ifdef ALU_SEQ_DIV_EN
    // One restoring step: shift next dividend bit into the remainder, subtract if it fits
    assign div_tmp  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign div_ge   = (div_tmp >= {1'b0, opnd});
    assign div_rem  = div_ge ? (div_tmp - {1'b0, opnd}) : div_tmp;
    assign div_step = {div_rem[WIDTH-1:0], acc[WIDTH-2:0], div_ge};
`endif

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept && is_mult)
                    state_nxt = S_MUL;
`ifdef ALU_SEQ_DIV_EN
                else if (accept && is_div && (op_b != '0))
                    state_nxt = S_DIV;
`endif
            end
            default: if (last_iter) state_nxt = S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy = (state != S_IDLE);
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ALU_aluOp <= '0;
            out_valid <= 1'b0;
            illegal   <= 1'b0;
            done      <= 1'b0;
            hi        <= '0;
            lo        <= '0;
            div_zero  <= 1'b0;
            cnt       <= '0;
            acc       <= '0;
            opnd      <= '0;
        end else begin
            out_valid <= accept;
            done      <= 1'b0;
            if (accept) begin
                ALU_aluOp <= dec_op;
                illegal   <= dec_illegal;
                div_zero  <= 1'b0;
                cnt       <= '0;
                if (is_mult) begin
                    acc  <= {{WIDTH{1'b0}}, op_b};
                    opnd <= op_a;
                end
`ifdef ALU_SEQ_DIV_EN
                if (is_div) begin
                    if (op_b == '0) begin
                        // Divide by zero completes in the accept cycle without iterating
                        hi       <= op_a;
                        lo       <= '1;
                        div_zero <= 1'b1;
                        done     <= 1'b1;
                    end else begin
                        acc  <= {{WIDTH{1'b0}}, op_a};
                        opnd <= op_b;
                    end
                end
`endif
            end else if (state == S_MUL) begin
                acc <= mul_step;
                cnt <= cnt + 1'b1;
                if (last_iter) begin
                    {hi, lo} <= mul_step;
                    done     <= 1'b1;
                end
            end
`ifdef ALU_SEQ_DIV_EN
            else if (state == S_DIV) begin
                acc <= div_step;
                cnt <= cnt + 1'b1;
                if (last_iter) begin
                    {hi, lo} <= div_step;
                    done     <= 1'b1;
                end
            end
`endif
        end
    end

endmodule
